// File: rtl/vc32_bus_pkg.sv
// vc32_bus_pkg: shared bus index width, FSM encoding, default doorbell index and byte-index helper
package vc32_bus_pkg;
  localparam int BUS_IDX_W = 15;
  localparam logic [8:0] DOORBELL_DEF = 9'h1FF;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  function automatic logic [BUS_IDX_W-1:0] byte_idx(input logic [7:0] hi, input logic [5:0] lo, input logic ind);
    return {hi, lo, ind};
  endfunction
endpackage

// File: rtl/vc32_byte_ram.sv
// vc32_byte_ram: 2^ADDR_W x 8 memory; comb read + sync write (bus), registered read/write (host)
module vc32_byte_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              host_en_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [7:0]        host_wdata_i,
  output logic [7:0]        host_rdata_o
);
  logic [7:0] mem_q [0:(1<<ADDR_W)-1];
  logic [7:0] host_rdata_q;
  assign rd_data_o = mem_q[rd_addr_i];
  assign host_rdata_o = host_rdata_q;
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (host_en_i && host_we_i) mem_q[host_addr_i] <= host_wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) host_rdata_q <= 8'h00;
    else if (host_en_i) host_rdata_q <= mem_q[host_addr_i];
  end
endmodule

// File: rtl/vc32_bus_target.sv
// vc32_bus_target: responder for the vc32 8-bit multiplexed memory bus with host port and doorbell irq
module vc32_bus_target
  import vc32_bus_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter logic [ADDR_W-1:0] DOORBELL = ADDR_W'(DOORBELL_DEF)
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              ena,
  input  logic [7:0]        bus_d,
  input  logic              latch_hi,
  input  logic              latch_lo,
  input  logic              write,
  input  logic              ind,
  output logic [7:0]        rd_data,
  output logic              irq,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  input  logic              irq_clr,
  output logic              proto_err
);
  state_t state_q, state_d;
  logic [7:0] hi_q, hi_d;
  logic [5:0] lo_q, lo_d;
  logic irq_q, irq_d, perr_q, perr_d, ack_q;
  logic [ADDR_W-1:0] ra;
  logic [7:0] ram_rd;
  logic bus_we, host_ok;
  assign ra = ADDR_W'(byte_idx(hi_q, state_q == ADDR ? bus_d[7:2] : lo_q, ind));
  assign bus_we = ena && !reset_in && state_q == DATA && write;
  assign host_ok = host_en && !reset_in && !(bus_we && ra == host_addr);
  assign rd_data = (state_q == DATA || (state_q == ADDR && latch_lo)) ? ram_rd : 8'h00;
  assign irq = irq_q;
  assign proto_err = perr_q;
  assign host_ack = ack_q;
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    perr_d = perr_q;
    irq_d = irq_q;
    if (ena) begin
      if (latch_hi) begin
        hi_d = bus_d;
        state_d = ADDR;
      end else if (latch_lo && state_q == ADDR) begin
        lo_d = bus_d[7:2];
        state_d = DATA;
      end
      if ((latch_lo && (latch_hi || state_q != ADDR)) || (write && state_q != DATA)) perr_d = 1'b1;
      irq_d = (bus_we && ra == DOORBELL) ? 1'b1 : irq_clr ? 1'b0 : irq_q;
    end
  end
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
    if (reset_in) begin
      state_q <= IDLE;
      irq_q <= 1'b0;
      perr_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q <= irq_d;
      perr_q <= perr_d;
      ack_q <= host_ok;
    end
  end
  vc32_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst(reset_in),
    .rd_addr_i(ra),
    .rd_data_o(ram_rd),
    .wr_en_i(bus_we),
    .wr_addr_i(ra),
    .wr_data_i(bus_d),
    .host_en_i(host_ok),
    .host_we_i(host_we),
    .host_addr_i(host_addr),
    .host_wdata_i(host_wdata),
    .host_rdata_o(host_rdata)
  );
endmodule

// File: tb/tb_vc32_bus_target.sv
// tb_vc32_bus_target: directed self-checking bench for vc32_bus_target
module tb_vc32_bus_target;
  logic clk = 1'b0;
  logic reset_in, ena, latch_hi, latch_lo, write, ind, irq, host_en, host_we, host_ack, irq_clr, proto_err;
  logic [7:0] bus_d, rd_data, host_wdata, host_rdata;
  logic [8:0] host_addr;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  vc32_bus_target dut (
    .clk(clk), .reset_in(reset_in), .ena(ena), .bus_d(bus_d),
    .latch_hi(latch_hi), .latch_lo(latch_lo), .write(write), .ind(ind),
    .rd_data(rd_data), .irq(irq), .host_en(host_en), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_ack(host_ack), .irq_clr(irq_clr), .proto_err(proto_err)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got %h exp %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic bus(input logic lh, input logic ll, input logic wr, input logic in, input logic [7:0] d);
    latch_hi = lh; latch_lo = ll; write = wr; ind = in; bus_d = d;
  endtask
  task automatic host_wr(input logic [8:0] a, input logic [7:0] d);
    host_en = 1; host_we = 1; host_addr = a; host_wdata = d;
    step();
    host_en = 0; host_we = 0;
    chk("host_wr_ack", {7'b0, host_ack}, 8'h01);
  endtask
  task automatic host_rd(input string tag, input logic [8:0] a, input logic [7:0] exp);
    host_en = 1; host_we = 0; host_addr = a;
    step();
    host_en = 0;
    chk(tag, host_rdata, exp);
  endtask
  initial begin
    reset_in = 1; ena = 1; host_en = 0; host_we = 0; host_addr = 0; host_wdata = 0; irq_clr = 0;
    bus(0, 0, 0, 0, 8'h00);
    step(); step();
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_perr", {7'b0, proto_err}, 8'h00);
    chk("rst_ack", {7'b0, host_ack}, 8'h00);
    chk("rst_hrdata", host_rdata, 8'h00);
    chk("rst_rd", rd_data, 8'h00);
    reset_in = 0;
    host_wr(9'h12A, 8'h5A);
    host_wr(9'h12B, 8'hC3);
    host_wr(9'h088, 8'hAA);
    host_wr(9'h089, 8'h55);
    // read: index {02, 54>>2, ind} = 0x12A / 0x12B
    bus(1, 0, 0, 0, 8'h02); #1 chk("rd_hi_zero", rd_data, 8'h00); step();
    bus(0, 1, 0, 0, 8'h54); #1 chk("rd_lo_b0", rd_data, 8'h5A); step();
    bus(0, 0, 0, 1, 8'h00); #1 chk("rd_b1", rd_data, 8'hC3); step();
    bus(0, 0, 0, 0, 8'h00); step();
    // single-lane write: {01, 10>>2, 1} = 0x089
    bus(1, 0, 0, 0, 8'h01); step();
    bus(0, 1, 0, 0, 8'h10); step();
    bus(0, 0, 1, 1, 8'h77); #1 chk("wr_prewrite", rd_data, 8'h55); step();
    bus(0, 0, 0, 0, 8'h00);
    host_rd("wr_lane1", 9'h089, 8'h77);
    host_rd("wr_lane0_keep", 9'h088, 8'hAA);
    // two-cycle write to 0x08A/0x08B with a conflicting host write
    bus(1, 0, 0, 0, 8'h01); step();
    bus(0, 1, 0, 0, 8'h14); step();
    bus(0, 0, 1, 0, 8'h11); host_en = 1; host_we = 1; host_addr = 9'h08A; host_wdata = 8'hEE; step();
    host_en = 0; host_we = 0;
    chk("conflict_nack", {7'b0, host_ack}, 8'h00);
    bus(0, 0, 1, 1, 8'h22); step();
    bus(0, 0, 0, 0, 8'h00);
    host_rd("wr2_lane0", 9'h08A, 8'h11);
    host_rd("wr2_lane1", 9'h08B, 8'h22);
    // doorbell {03, FC>>2, 1} = 0x1FF
    bus(1, 0, 0, 0, 8'h03); step();
    bus(0, 1, 0, 0, 8'hFC); step();
    bus(0, 0, 1, 1, 8'h99); #1 chk("irq_pre", {7'b0, irq}, 8'h00); step();
    bus(0, 0, 0, 0, 8'h00);
    chk("irq_set", {7'b0, irq}, 8'h01);
    irq_clr = 1; step(); irq_clr = 0;
    chk("irq_clr", {7'b0, irq}, 8'h00);
    bus(0, 0, 1, 1, 8'h98); irq_clr = 1; step(); irq_clr = 0;
    bus(0, 0, 0, 0, 8'h00);
    chk("irq_set_wins", {7'b0, irq}, 8'h01);
    chk("perr_clean", {7'b0, proto_err}, 8'h00);
    // protocol errors
    reset_in = 1; step(); reset_in = 0;
    chk("rst_irq2", {7'b0, irq}, 8'h00);
    bus(0, 1, 0, 0, 8'h00); #1 chk("idle_lo_rd", rd_data, 8'h00); step();
    bus(0, 0, 0, 0, 8'h00);
    chk("perr_lo_idle", {7'b0, proto_err}, 8'h01);
    reset_in = 1; step(); reset_in = 0;
    chk("perr_rst", {7'b0, proto_err}, 8'h00);
    bus(1, 0, 0, 0, 8'h01); step();
    bus(0, 0, 1, 1, 8'h22); #1 chk("addr_rd_zero", rd_data, 8'h00); step();
    bus(0, 0, 0, 0, 8'h00);
    chk("perr_wr_addr", {7'b0, proto_err}, 8'h01);
    host_rd("wr_addr_nowrite", 9'h089, 8'h77);
    host_rd("wr_addr_nowrite2", 9'h08B, 8'h22);
    // reset between LO and W0
    reset_in = 1; step(); reset_in = 0;
    bus(1, 0, 0, 0, 8'h01); step();
    bus(0, 1, 0, 0, 8'h10); step();
    reset_in = 1; step(); reset_in = 0;
    bus(0, 0, 1, 1, 8'h44); #1 chk("midrst_rd", rd_data, 8'h00); step();
    bus(0, 0, 0, 0, 8'h00);
    chk("midrst_perr", {7'b0, proto_err}, 8'h01);
    host_rd("midrst_nowrite", 9'h089, 8'h77);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
